// File: rtl/mem_io_responder.sv
// CPU-facing memory/IO responder: byte RAM, UART tx/rx FIFOs, stop flag and
// a free-running cycle counter with a four-byte snapshot readout.
module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH_LOG = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        program_stop
);

   localparam int RAM_DEPTH = 2 ** RAM_ADDR_WIDTH;
   localparam int DEPTH     = 2 ** FIFO_DEPTH_LOG;
   localparam int CNT_W     = FIFO_DEPTH_LOG + 1;

   localparam logic [17:0] IO_UART  = 18'h30000;
   localparam logic [17:0] IO_CNT_0 = 18'h30004;
   localparam logic [17:0] IO_CNT_1 = 18'h30005;
   localparam logic [17:0] IO_CNT_2 = 18'h30006;
   localparam logic [17:0] IO_CNT_3 = 18'h30007;

   logic [7:0]                ram [0:RAM_DEPTH-1];
   logic [RAM_ADDR_WIDTH-1:0] ram_addr;
   logic [17:0]               io_addr;
   logic                      io_sel;
   logic                      io_rd;
   logic                      io_wr;
   logic                      unused_addr_bits;

   logic [7:0]                tx_mem [0:DEPTH-1];
   logic [FIFO_DEPTH_LOG-1:0] tx_wr_ptr;
   logic [FIFO_DEPTH_LOG-1:0] tx_rd_ptr;
   logic [CNT_W-1:0]          tx_count;
   logic                      tx_full;
   logic                      tx_push;
   logic                      tx_pop;

   logic [7:0]                rx_mem [0:DEPTH-1];
   logic [FIFO_DEPTH_LOG-1:0] rx_wr_ptr;
   logic [FIFO_DEPTH_LOG-1:0] rx_rd_ptr;
   logic [CNT_W-1:0]          rx_count;
   logic                      rx_full;
   logic                      rx_empty;
   logic                      rx_push;
   logic                      rx_pop;

   logic [31:0]               cycle_cnt;
   logic [31:0]               snapshot;

   assign unused_addr_bits = ^mem_a[31:18];

   assign io_addr  = mem_a[17:0];
   assign ram_addr = mem_a[RAM_ADDR_WIDTH-1:0];
   assign io_sel   = (mem_a[17:16] == 2'b11);
   assign io_rd    = io_sel && !mem_wr;
   assign io_wr    = io_sel && mem_wr;

   // tx FIFO: a pop in the same cycle frees the slot a full-FIFO push needs
   assign tx_full        = (tx_count == CNT_W'(DEPTH));
   assign tx_valid       = (tx_count != '0);
   assign tx_data        = tx_mem[tx_rd_ptr];
   assign tx_pop         = tx_valid && tx_ready;
   assign tx_push        = io_wr && (io_addr == IO_UART) && (mem_dout != 8'h00)
                           && (!tx_full || tx_pop);
   assign io_buffer_full = (tx_count >= CNT_W'(DEPTH - 1));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= mem_dout;
   end

   // rx FIFO: an empty-FIFO read returns 0 without popping, so a same-cycle push survives
   assign rx_full  = (rx_count == CNT_W'(DEPTH));
   assign rx_empty = (rx_count == '0);
   assign rx_push  = rx_valid && !rx_full;
   assign rx_pop   = io_rd && (io_addr == IO_UART) && !rx_empty;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
   end

   // RAM contents deliberately survive reset
   always_ff @(posedge clk_in) begin
      if (mem_wr && !io_sel) ram[ram_addr] <= mem_dout;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem_din      <= 8'h00;
         program_stop <= 1'b0;
         cycle_cnt    <= 32'd0;
         snapshot     <= 32'd0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (io_wr && (io_addr == IO_CNT_0)) program_stop <= 1'b1;
         if (!mem_wr) begin
            if (!io_sel) begin
               mem_din <= ram[ram_addr];
            end else begin
               case (io_addr)
                  IO_UART:  mem_din <= rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
                  IO_CNT_0: begin
                     snapshot <= cycle_cnt;
                     mem_din  <= cycle_cnt[7:0];
                  end
                  IO_CNT_1: mem_din <= snapshot[15:8];
                  IO_CNT_2: mem_din <= snapshot[23:16];
                  IO_CNT_3: mem_din <= snapshot[31:24];
                  default:  mem_din <= 8'h00;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, tx/rx FIFOs, counter snapshot,
// stop flag and asynchronous reset behaviour.
module tb_mem_io_responder;

   logic        clk_in;
   logic        rst_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        program_stop;

   int n_vec;
   int n_err;

   mem_io_responder #(.RAM_ADDR_WIDTH(17), .FIFO_DEPTH_LOG(3)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .program_stop   (program_stop)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Present one request at a falling edge, let one rising edge consume it,
   // return at the next falling edge with the bus back to an idle RAM read.
   task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
      @(negedge clk_in);
      mem_a    = 32'h0;
      mem_wr   = 1'b0;
      mem_dout = 8'h00;
   endtask

   task automatic test_reset;
      rst_in = 1'b1;
      repeat (2) @(negedge clk_in);
      n_vec++;
      if (mem_din !== 8'h00) begin
         n_err++; $display("FAIL reset_mem_din got=%h exp=00", mem_din);
      end
      n_vec++;
      if (tx_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid);
      end
      n_vec++;
      if (program_stop !== 1'b0) begin
         n_err++; $display("FAIL reset_program_stop got=%b exp=0", program_stop);
      end
      n_vec++;
      if (io_buffer_full !== 1'b0) begin
         n_err++; $display("FAIL reset_io_buffer_full got=%b exp=0", io_buffer_full);
      end
      rst_in = 1'b0;
   endtask

   // Entered at the falling edge where reset was released: after k rising
   // edges the counter holds k.
   task automatic test_counter;
      repeat (300) @(negedge clk_in);
      cyc(32'h30004, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h2C) begin
         n_err++; $display("FAIL cnt300_b0 got=%h exp=2c", mem_din);
      end
      cyc(32'h30005, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h01) begin
         n_err++; $display("FAIL cnt300_b1 got=%h exp=01", mem_din);
      end
      cyc(32'h30006, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h00) begin
         n_err++; $display("FAIL cnt300_b2 got=%h exp=00", mem_din);
      end
      cyc(32'h30007, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h00) begin
         n_err++; $display("FAIL cnt300_b3 got=%h exp=00", mem_din);
      end
      // counter is 304 here; advance to 511 so a recapture would show 0x02
      repeat (207) @(negedge clk_in);
      cyc(32'h30004, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'hFF) begin
         n_err++; $display("FAIL cnt511_b0 got=%h exp=ff", mem_din);
      end
      cyc(32'h30005, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h01) begin
         n_err++; $display("FAIL cnt511_b1 got=%h exp=01", mem_din);
      end
   endtask

   task automatic test_ram;
      cyc(32'h00104, 1'b1, 8'hA5);
      n_vec++;
      if (mem_din !== 8'h01) begin
         n_err++; $display("FAIL ram_write_holds_din got=%h exp=01", mem_din);
      end
      cyc(32'h00104, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'hA5) begin
         n_err++; $display("FAIL ram_rd_104 got=%h exp=a5", mem_din);
      end
      cyc(32'h1FFFF, 1'b1, 8'h5A);
      cyc(32'h1FFFF, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h5A) begin
         n_err++; $display("FAIL ram_rd_top got=%h exp=5a", mem_din);
      end
      cyc(32'h20104, 1'b1, 8'h3C);
      cyc(32'h00104, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h3C) begin
         n_err++; $display("FAIL ram_alias_104 got=%h exp=3c", mem_din);
      end
      cyc(32'h30008, 1'b1, 8'h77);
      cyc(32'h30008, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h00) begin
         n_err++; $display("FAIL io_unmapped_rd got=%h exp=00", mem_din);
      end
      n_vec++;
      if (tx_valid !== 1'b0 || program_stop !== 1'b0) begin
         n_err++; $display("FAIL io_unmapped_wr got=%b%b exp=00", tx_valid, program_stop);
      end
   endtask

   task automatic test_tx;
      tx_ready = 1'b0;
      cyc(32'h30000, 1'b1, 8'h41);
      cyc(32'h30000, 1'b1, 8'h00);
      cyc(32'h30000, 1'b1, 8'h42);
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
         n_err++; $display("FAIL tx_head got=%b/%h exp=1/41", tx_valid, tx_data);
      end
      n_vec++;
      if (io_buffer_full !== 1'b0) begin
         n_err++; $display("FAIL tx_not_full got=%b exp=0", io_buffer_full);
      end
      tx_ready = 1'b1;
      @(negedge clk_in);
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin
         n_err++; $display("FAIL tx_second got=%b/%h exp=1/42", tx_valid, tx_data);
      end
      @(negedge clk_in);
      n_vec++;
      if (tx_valid !== 1'b0) begin
         n_err++; $display("FAIL tx_drained got=%b exp=0", tx_valid);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_tx_full;
      logic [7:0] exp_q [8];
      exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
      tx_ready = 1'b0;
      for (int i = 1; i <= 6; i++) cyc(32'h30000, 1'b1, 8'(i));
      n_vec++;
      if (io_buffer_full !== 1'b0) begin
         n_err++; $display("FAIL full_at6 got=%b exp=0", io_buffer_full);
      end
      cyc(32'h30000, 1'b1, 8'h07);
      n_vec++;
      if (io_buffer_full !== 1'b1) begin
         n_err++; $display("FAIL full_at7 got=%b exp=1", io_buffer_full);
      end
      cyc(32'h30000, 1'b1, 8'h08);
      cyc(32'h30000, 1'b1, 8'h09);
      n_vec++;
      if (tx_data !== 8'h01 || io_buffer_full !== 1'b1) begin
         n_err++; $display("FAIL full_head got=%h/%b exp=01/1", tx_data, io_buffer_full);
      end
      tx_ready = 1'b1;
      cyc(32'h30000, 1'b1, 8'h0A);
      n_vec++;
      if (tx_data !== 8'h02 || io_buffer_full !== 1'b1) begin
         n_err++; $display("FAIL full_push_pop got=%h/%b exp=02/1", tx_data, io_buffer_full);
      end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
            n_err++;
            $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[i]);
         end
         @(negedge clk_in);
      end
      n_vec++;
      if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
         n_err++; $display("FAIL drain_empty got=%b/%b exp=0/0", tx_valid, io_buffer_full);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_rx;
      logic [7:0] exp_r [9];
      rx_valid = 1'b1;
      rx_data  = 8'h31;
      @(negedge clk_in);
      rx_data  = 8'h32;
      @(negedge clk_in);
      rx_valid = 1'b0;
      exp_r[0] = 8'h31; exp_r[1] = 8'h32; exp_r[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         cyc(32'h30000, 1'b0, 8'h00);
         n_vec++;
         if (mem_din !== exp_r[i]) begin
            n_err++; $display("FAIL rx_rd_%0d got=%h exp=%h", i, mem_din, exp_r[i]);
         end
      end
      rx_valid = 1'b1;
      rx_data  = 8'h77;
      cyc(32'h30000, 1'b0, 8'h00);
      rx_valid = 1'b0;
      n_vec++;
      if (mem_din !== 8'h00) begin
         n_err++; $display("FAIL rx_empty_pushpop got=%h exp=00", mem_din);
      end
      cyc(32'h30000, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h77) begin
         n_err++; $display("FAIL rx_retained got=%h exp=77", mem_din);
      end
      rx_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rx_data = 8'h80 + 8'(i);
         @(negedge clk_in);
      end
      rx_valid = 1'b0;
      for (int i = 0; i < 8; i++) exp_r[i] = 8'h80 + 8'(i);
      exp_r[8] = 8'h00;
      for (int i = 0; i < 9; i++) begin
         cyc(32'h30000, 1'b0, 8'h00);
         n_vec++;
         if (mem_din !== exp_r[i]) begin
            n_err++; $display("FAIL rx_ovf_%0d got=%h exp=%h", i, mem_din, exp_r[i]);
         end
      end
   endtask

   task automatic test_stop_reset;
      tx_ready = 1'b0;
      cyc(32'h30000, 1'b1, 8'h55);
      cyc(32'h30004, 1'b1, 8'h00);
      n_vec++;
      if (program_stop !== 1'b1 || tx_valid !== 1'b1) begin
         n_err++; $display("FAIL stop_set got=%b/%b exp=1/1", program_stop, tx_valid);
      end
      repeat (3) @(negedge clk_in);
      n_vec++;
      if (program_stop !== 1'b1) begin
         n_err++; $display("FAIL stop_sticky got=%b exp=1", program_stop);
      end
      #2 rst_in = 1'b1;
      #1;
      n_vec++;
      if (program_stop !== 1'b0 || tx_valid !== 1'b0 || mem_din !== 8'h00) begin
         n_err++;
         $display("FAIL async_reset got=%b/%b/%h exp=0/0/00", program_stop, tx_valid, mem_din);
      end
      @(negedge clk_in);
      rst_in = 1'b0;
      cyc(32'h00104, 1'b0, 8'h00);
      n_vec++;
      if (mem_din !== 8'h3C) begin
         n_err++; $display("FAIL ram_kept_over_reset got=%h exp=3c", mem_din);
      end
      n_vec++;
      if (program_stop !== 1'b0 || tx_valid !== 1'b0) begin
         n_err++; $display("FAIL post_reset got=%b/%b exp=0/0", program_stop, tx_valid);
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst_in   = 1'b1;
      mem_a    = 32'h0;
      mem_wr   = 1'b0;
      mem_dout = 8'h00;
      tx_ready = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      test_reset();
      test_counter();
      test_ram();
      test_tx();
      test_tx_full();
      test_rx();
      test_stop_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
